// File: rtl/bcd_converter.sv
// Multi-cycle binary-to-BCD converter (shift-add-3) with saturating overflow,
// leading-zero blanking mask and valid/ready handshakes on both sides.
module bcd_converter #(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      binary_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow,
    output logic [DIGITS-1:0]     digit_nz,
    output logic                  busy
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [BIN_W-1:0]  bin_shift;
    logic [BCD_W-1:0]  bcd_work;
    logic [CNT_W-1:0]  cnt;
    logic              sticky;

    logic              accept;
    logic              last_shift;
    logic [BCD_W-1:0]  adjusted;
    logic [BCD_W-1:0]  work_next;
    logic [BIN_W-1:0]  bin_next;
    logic              carry;
    logic              sticky_next;
    logic [BCD_W-1:0]  result;
    logic [DIGITS-1:0] nz_next;
    logic              running;

    assign in_ready   = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept     = in_valid && in_ready;
    assign busy       = (state == SHIFT);
    assign last_shift = (state == SHIFT) && (cnt == CNT_W'(1));

    // Add-3 correction, then one left shift; the bit leaving the top digit
    // means the value no longer fits in DIGITS digits.
    always_comb begin
        adjusted = bcd_work;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_work[4*i +: 4] >= 4'd5) begin
                adjusted[4*i +: 4] = bcd_work[4*i +: 4] + 4'd3;
            end
        end
        {carry, work_next, bin_next} = {adjusted, bin_shift, 1'b0};
        sticky_next = sticky | carry;
        result      = sticky_next ? {DIGITS{4'h9}} : work_next;
    end

    // Blanking mask: a digit is shown if it or any more significant digit is nonzero.
    always_comb begin
        running = 1'b0;
        nz_next = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            running = running | (result[4*(DIGITS-1-k) +: 4] != 4'd0);
            nz_next[DIGITS-1-k] = running;
        end
        nz_next[0] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (last_shift) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = in_valid ? SHIFT : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_shift <= '0;
            bcd_work  <= '0;
            cnt       <= '0;
            sticky    <= 1'b0;
            bcd       <= '0;
            overflow  <= 1'b0;
            digit_nz  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                bin_shift <= binary_in;
                bcd_work  <= '0;
                sticky    <= 1'b0;
                cnt       <= CNT_W'(BIN_W);
            end else if (state == SHIFT) begin
                bin_shift <= bin_next;
                bcd_work  <= work_next;
                sticky    <= sticky_next;
                cnt       <= cnt - CNT_W'(1);
            end

            if (last_shift) begin
                bcd       <= result;
                overflow  <= sticky_next;
                digit_nz  <= nz_next;
                out_valid <= 1'b1;
            end else if ((state == DONE) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bcd_converter.sv
// Self-checking bench for bcd_converter: three instances (32b/10 digits,
// 32b/7 digits, 1b/1 digit) against an arithmetic decimal reference model.
module tb_bcd_converter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        iv_a, ir_a, ov_a, or_a, ovf_a, busy_a;
    logic [31:0] bin_a;
    logic [39:0] bcd_a;
    logic [9:0]  nz_a;

    logic        iv_b, ir_b, ov_b, or_b, ovf_b, busy_b;
    logic [31:0] bin_b;
    logic [27:0] bcd_b;
    logic [6:0]  nz_b;

    logic        iv_c, ir_c, ov_c, or_c, ovf_c, busy_c;
    logic [0:0]  bin_c;
    logic [3:0]  bcd_c;
    logic [0:0]  nz_c;

    int checks = 0;
    int errors = 0;

    bcd_converter #(.BIN_W(32), .DIGITS(10)) dut_a (
        .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(ir_a), .binary_in(bin_a),
        .out_valid(ov_a), .out_ready(or_a), .bcd(bcd_a), .overflow(ovf_a),
        .digit_nz(nz_a), .busy(busy_a)
    );

    bcd_converter #(.BIN_W(32), .DIGITS(7)) dut_b (
        .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(ir_b), .binary_in(bin_b),
        .out_valid(ov_b), .out_ready(or_b), .bcd(bcd_b), .overflow(ovf_b),
        .digit_nz(nz_b), .busy(busy_b)
    );

    bcd_converter #(.BIN_W(1), .DIGITS(1)) dut_c (
        .clk(clk), .rst(rst), .in_valid(iv_c), .in_ready(ir_c), .binary_in(bin_c),
        .out_valid(ov_c), .out_ready(or_c), .bcd(bcd_c), .overflow(ovf_c),
        .digit_nz(nz_c), .busy(busy_c)
    );

    // ---------------- reference model: plain decimal arithmetic ----------------
    function automatic longint unsigned pow10(input int n);
        longint unsigned r = 1;
        repeat (n) r = r * 10;
        return r;
    endfunction

    function automatic logic m_ovf(input longint unsigned v, input int d);
        return v > pow10(d) - 1;
    endfunction

    function automatic logic [39:0] m_bcd(input longint unsigned v, input int d);
        longint unsigned sat;
        logic [39:0] r;
        sat = m_ovf(v, d) ? pow10(d) - 1 : v;
        r = '0;
        for (int i = 0; i < d; i++) r[4*i +: 4] = 4'((sat / pow10(i)) % 10);
        return r;
    endfunction

    function automatic logic [9:0] m_nz(input longint unsigned v, input int d);
        longint unsigned sat;
        logic [9:0] r;
        sat = m_ovf(v, d) ? pow10(d) - 1 : v;
        r = '0;
        for (int i = 0; i < d; i++) r[i] = (i == 0) || (sat >= pow10(i));
        return r;
    endfunction

    function automatic int digits_of(input int sel);
        return (sel == 0) ? 10 : (sel == 1) ? 7 : 1;
    endfunction

    // ---------------- per-instance access ----------------
    function automatic logic rdy(input int sel);
        return (sel == 0) ? ir_a : (sel == 1) ? ir_b : ir_c;
    endfunction
    function automatic logic vld(input int sel);
        return (sel == 0) ? ov_a : (sel == 1) ? ov_b : ov_c;
    endfunction
    function automatic logic bsy(input int sel);
        return (sel == 0) ? busy_a : (sel == 1) ? busy_b : busy_c;
    endfunction
    function automatic logic [39:0] obs_bcd(input int sel);
        return (sel == 0) ? bcd_a : (sel == 1) ? {12'h0, bcd_b} : {36'h0, bcd_c};
    endfunction
    function automatic logic obs_ovf(input int sel);
        return (sel == 0) ? ovf_a : (sel == 1) ? ovf_b : ovf_c;
    endfunction
    function automatic logic [9:0] obs_nz(input int sel);
        return (sel == 0) ? nz_a : (sel == 1) ? {3'b0, nz_b} : {9'b0, nz_c};
    endfunction

    task automatic set_in(input int sel, input logic v, input logic [31:0] val);
        case (sel)
            0: begin iv_a = v; bin_a = val; end
            1: begin iv_b = v; bin_b = val; end
            default: begin iv_c = v; bin_c = val[0]; end
        endcase
    endtask

    task automatic set_ordy(input int sel, input logic v);
        case (sel)
            0: or_a = v;
            1: or_b = v;
            default: or_c = v;
        endcase
    endtask

    // Drives one conversion from a negedge; returns latency, busy cycles and result.
    task automatic convert(input int sel, input logic [31:0] v, input bit release_out,
                           output int lat, output int busy_n, output logic [39:0] b,
                           output logic o, output logic [9:0] nz, output bit timeout);
        int w = 0;
        timeout = 0;
        while (!rdy(sel) && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) timeout = 1;
        set_in(sel, 1'b1, v);
        @(negedge clk);
        set_in(sel, 1'b0, 32'h0);
        lat = 0;
        busy_n = 0;
        while (!vld(sel) && lat < 200) begin
            if (bsy(sel)) busy_n++;
            @(negedge clk);
            lat++;
        end
        if (lat >= 200) timeout = 1;
        b  = obs_bcd(sel);
        o  = obs_ovf(sel);
        nz = obs_nz(sel);
        if (release_out) begin
            set_ordy(sel, 1'b1);
            @(negedge clk);
            set_ordy(sel, 1'b0);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        iv_a = 0; iv_b = 0; iv_c = 0; or_a = 0; or_b = 0; or_c = 0;
        bin_a = '0; bin_b = '0; bin_c = '0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (rdy(s) !== 1'b1 || vld(s) !== 1'b0 || bsy(s) !== 1'b0) begin
                errors++;
                $display("FAIL reset_ctrl[%0d]: ready/valid/busy got %b%b%b expected 100",
                         s, rdy(s), vld(s), bsy(s));
            end
            checks++;
            if (obs_bcd(s) !== 40'h0 || obs_ovf(s) !== 1'b0 || obs_nz(s) !== 10'h0) begin
                errors++;
                $display("FAIL reset_data[%0d]: bcd=%h ovf=%b nz=%b expected all zero",
                         s, obs_bcd(s), obs_ovf(s), obs_nz(s));
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_conv(input int sel, input logic [31:0] v, input int exp_lat);
        int lat, bn;
        logic [39:0] b;
        logic o;
        logic [9:0] nz;
        bit to;
        int d;
        d = digits_of(sel);
        convert(sel, v, 1'b1, lat, bn, b, o, nz, to);
        checks++;
        if (to || lat !== exp_lat || bn !== exp_lat) begin
            errors++;
            $display("FAIL latency[%0d] v=%0d: lat=%0d busy=%0d timeout=%0b expected %0d",
                     sel, v, lat, bn, to, exp_lat);
        end
        checks++;
        if (b !== m_bcd(v, d)) begin
            errors++;
            $display("FAIL bcd[%0d] v=%0d: got %h expected %h", sel, v, b, m_bcd(v, d));
        end
        checks++;
        if (o !== m_ovf(v, d)) begin
            errors++;
            $display("FAIL overflow[%0d] v=%0d: got %b expected %b", sel, v, o, m_ovf(v, d));
        end
        checks++;
        if (nz !== m_nz(v, d)) begin
            errors++;
            $display("FAIL digit_nz[%0d] v=%0d: got %b expected %b", sel, v, nz, m_nz(v, d));
        end
    endtask

    task automatic test_convert_full();
        logic [31:0] vals [6] = '{32'd12345, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd10, 32'd1000000000};
        foreach (vals[i]) check_conv(0, vals[i], 32);
        for (int i = 0; i < 8; i++) check_conv(0, $urandom, 32);
        for (int i = 0; i < 4; i++) check_conv(0, $urandom_range(0, 99999), 32);
    endtask

    task automatic test_digits7();
        logic [31:0] vals [5] = '{32'd12345678, 32'd9999999, 32'd10000000, 32'd0, 32'hFFFF_FFFF};
        foreach (vals[i]) check_conv(1, vals[i], 32);
        for (int i = 0; i < 6; i++) check_conv(1, $urandom_range(9000000, 11000000), 32);
        for (int i = 0; i < 3; i++) check_conv(1, $urandom, 32);
    endtask

    task automatic test_width1();
        check_conv(2, 32'd1, 1);
        check_conv(2, 32'd0, 1);
        check_conv(2, 32'd1, 1);
    endtask

    task automatic test_back_to_back();
        int lat, bn;
        logic [39:0] b, held;
        logic o;
        logic [9:0] nz;
        bit to;
        convert(0, 32'd777, 1'b0, lat, bn, b, o, nz, to);
        held = b;
        checks++;
        if (to || b !== m_bcd(777, 10)) begin
            errors++;
            $display("FAIL bp_first: got %h expected %h", b, m_bcd(777, 10));
        end
        for (int i = 0; i < 5; i++) begin
            iv_a = i[0];
            bin_a = 32'd555;
            #1;
            checks++;
            if (ov_a !== 1'b1 || bcd_a !== held || ir_a !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: valid=%b ready=%b bcd=%h expected 1 0 %h",
                         i, ov_a, ir_a, bcd_a, held);
            end
            @(negedge clk);
        end
        iv_a = 1'b1;
        bin_a = 32'd42;
        or_a = 1'b1;
        #1;
        checks++;
        if (ir_a !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_comb: got %b expected 1", ir_a);
        end
        @(negedge clk);
        iv_a = 1'b0;
        or_a = 1'b0;
        checks++;
        if (busy_a !== 1'b1 || ov_a !== 1'b0 || ir_a !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b valid=%b ready=%b expected 1 0 0", busy_a, ov_a, ir_a);
        end
        lat = 0;
        while (!ov_a && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 32 || bcd_a !== 40'h42 || ovf_a !== 1'b0) begin
            errors++;
            $display("FAIL b2b_result: lat=%0d bcd=%h ovf=%b expected 32 0000000042 0", lat, bcd_a, ovf_a);
        end
        or_a = 1'b1;
        @(negedge clk);
        or_a = 1'b0;
        checks++;
        if (ov_a !== 1'b0 || ir_a !== 1'b1) begin
            errors++;
            $display("FAIL b2b_release: valid=%b ready=%b expected 0 1", ov_a, ir_a);
        end
    endtask

    task automatic test_reset_abort();
        bit seen = 0;
        iv_a = 1'b1;
        bin_a = 32'd123456;
        @(negedge clk);
        iv_a = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL abort_busy: got %b expected 1", busy_a);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (ov_a !== 1'b0 || busy_a !== 1'b0 || ir_a !== 1'b1 || bcd_a !== 40'h0) begin
            errors++;
            $display("FAIL abort_state: valid=%b busy=%b ready=%b bcd=%h expected 0 0 1 0",
                     ov_a, busy_a, ir_a, bcd_a);
        end
        for (int i = 0; i < 40; i++) begin
            if (ov_a) seen = 1;
            @(negedge clk);
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_result: out_valid seen=%b expected 0", seen);
        end
        check_conv(0, 32'd987, 32);
    endtask

    initial begin
        test_reset();
        test_convert_full();
        test_digits7();
        test_width1();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
